// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ALU control decode with two-entry skid output stage (optional illegal flag: ALU_CTRL_ILLEGAL_EN)
module alu_ctrl_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] Operation,
  output logic       illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_JAL = 4'b1111;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic [3:0] dec_op;
  logic       dec_ill;
  logic       is_itype;
  logic       f7_zero;
  logic       f7_alt;
  logic       base_ok;

  logic       main_valid;
  logic [3:0] main_op;
  logic       main_ill;
  logic       skid_valid;
  logic [3:0] skid_op;
  logic       skid_ill;

  logic       accept;
  logic       drain;

  assign is_itype = (opcode == 7'b0010011);
  assign f7_zero  = (funct7 == 7'b0000000);
  assign f7_alt   = (funct7 == 7'b0100000);
  // I-type ALU ops carry an immediate in funct7, so only R-type constrains it
  assign base_ok  = is_itype || f7_zero;

  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign Operation = main_op;
  assign illegal   = main_ill;

  // Decode the instruction fields into an ALU operation; unsupported encodings give 0000
  always_comb begin
    dec_op  = OP_AND;
    dec_ill = 1'b1;
    case (opcode)
      7'b0110011, 7'b0010011: begin
        case (funct3)
          3'b000: begin
            if (base_ok) begin
              dec_op  = OP_ADD;
              dec_ill = 1'b0;
            end else if (f7_alt) begin
              dec_op  = OP_SUB;
              dec_ill = 1'b0;
            end
          end
          3'b111: begin
            dec_op  = OP_AND;
            dec_ill = !base_ok;
          end
          3'b110: begin
            dec_op  = base_ok ? OP_OR : OP_AND;
            dec_ill = !base_ok;
          end
          3'b100: begin
            dec_op  = base_ok ? OP_XOR : OP_AND;
            dec_ill = !base_ok;
          end
          3'b010: begin
            dec_op  = base_ok ? OP_SLT : OP_AND;
            dec_ill = !base_ok;
          end
          3'b001: begin
            dec_op  = f7_zero ? OP_SLL : OP_AND;
            dec_ill = !f7_zero;
          end
          3'b101: begin
            if (f7_zero) begin
              dec_op  = OP_SRL;
              dec_ill = 1'b0;
            end else if (f7_alt) begin
              dec_op  = OP_SRA;
              dec_ill = 1'b0;
            end
          end
          default: ;
        endcase
      end
      7'b0000011, 7'b0100011, 7'b1100111: begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
      end
      7'b1100011: begin
        case (funct3)
          3'b000: begin
            dec_op  = OP_BEQ;
            dec_ill = 1'b0;
          end
          3'b001: begin
            dec_op  = OP_BNE;
            dec_ill = 1'b0;
          end
          3'b100: begin
            dec_op  = OP_SLT;
            dec_ill = 1'b0;
          end
          3'b101: begin
            dec_op  = OP_BGE;
            dec_ill = 1'b0;
          end
          default: ;
        endcase
      end
      7'b1101111: begin
        dec_op  = OP_JAL;
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  // Skid buffer: main drives the outputs, skid absorbs one entry while main is stalled
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_op    <= OP_AND;
      main_ill   <= 1'b0;
      skid_valid <= 1'b0;
      skid_op    <= OP_AND;
      skid_ill   <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_op    <= skid_op;
        main_ill   <= skid_ill;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_op  <= dec_op;
        main_ill <= dec_ill & ILL_EN;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_op    <= dec_op;
        skid_ill   <= dec_ill & ILL_EN;
      end else begin
        main_valid <= 1'b1;
        main_op    <= dec_op;
        main_ill   <= dec_ill & ILL_EN;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - directed self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Operation;
  logic       illegal;

  int checks;
  int failures;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  alu_ctrl_stage dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Operation (Operation),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    in_valid = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] op, input logic ill);
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'd1);
    chk({tag, "_op"}, {4'b0, Operation}, {4'b0, op});
    chk({tag, "_ill"}, {7'b0, illegal}, {7'b0, ill});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 7'b0;
    funct3    = 3'b0;
    funct7    = 7'b0;
    step();
    chk("rst_valid", {7'b0, out_valid}, 8'd0);
    chk("rst_ready", {7'b0, in_ready}, 8'd1);
    chk("rst_op", {4'b0, Operation}, 8'd0);
    chk("rst_ill", {7'b0, illegal}, 8'd0);
    reset = 1'b0;

    // streaming decode vectors, one per cycle, downstream always ready
    drive(7'b0110011, 3'b000, 7'b0100000); step(); expect_out("sub", 4'b0011, 1'b0);
    drive(7'b1100011, 3'b101, 7'b0000000); step(); expect_out("bge", 4'b1011, 1'b0);
    drive(7'b1101111, 3'b011, 7'b1010101); step(); expect_out("jal", 4'b1111, 1'b0);
    drive(7'b0010011, 3'b101, 7'b0100000); step(); expect_out("srai", 4'b0110, 1'b0);
    drive(7'b0010011, 3'b000, 7'b0100000); step(); expect_out("addi", 4'b0010, 1'b0);
    drive(7'b0000011, 3'b010, 7'b1111111); step(); expect_out("load", 4'b0010, 1'b0);
    drive(7'b0100011, 3'b000, 7'b0000000); step(); expect_out("store", 4'b0010, 1'b0);
    drive(7'b1100011, 3'b000, 7'b0000000); step(); expect_out("beq", 4'b1001, 1'b0);
    drive(7'b1100011, 3'b100, 7'b0000000); step(); expect_out("blt", 4'b1000, 1'b0);
    drive(7'b0110011, 3'b001, 7'b0000000); step(); expect_out("sll", 4'b0111, 1'b0);
    drive(7'b0110011, 3'b101, 7'b0000000); step(); expect_out("srl", 4'b0101, 1'b0);
    drive(7'b0010011, 3'b100, 7'b0110000); step(); expect_out("xori", 4'b0100, 1'b0);
    drive(7'b1111111, 3'b000, 7'b0000000); step(); expect_out("bad_opc", 4'b0000, EXP_ILL);
    drive(7'b0110011, 3'b000, 7'b0000001); step(); expect_out("bad_f7", 4'b0000, EXP_ILL);
    drive(7'b0110011, 3'b110, 7'b0000001); step(); expect_out("bad_or", 4'b0000, EXP_ILL);
    drive(7'b1100011, 3'b010, 7'b0000000); step(); expect_out("bad_br", 4'b0000, EXP_ILL);
    in_valid = 1'b0; step();
    chk("idle_valid", {7'b0, out_valid}, 8'd0);

    // backpressure: ADD, XOR, OR with out_ready low
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000); step();
    expect_out("bp_add", 4'b0010, 1'b0);
    chk("bp_ready1", {7'b0, in_ready}, 8'd1);
    drive(7'b0110011, 3'b100, 7'b0000000); step();
    chk("bp_ready2", {7'b0, in_ready}, 8'd0);
    expect_out("bp_hold1", 4'b0010, 1'b0);
    drive(7'b0110011, 3'b110, 7'b0000000); step();
    chk("bp_ready3", {7'b0, in_ready}, 8'd0);
    expect_out("bp_hold2", 4'b0010, 1'b0);
    out_ready = 1'b1; step();
    expect_out("bp_xor", 4'b0100, 1'b0);
    chk("bp_ready4", {7'b0, in_ready}, 8'd1);
    step();
    expect_out("bp_or", 4'b0001, 1'b0);
    in_valid = 1'b0; step();
    chk("bp_empty", {7'b0, out_valid}, 8'd0);

    // flush with both entries held and an input offered
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000); step();
    drive(7'b0110011, 3'b100, 7'b0000000); step();
    chk("fl_full", {7'b0, in_ready}, 8'd0);
    drive(7'b0110011, 3'b000, 7'b0100000); flush = 1'b1; step();
    chk("fl_valid", {7'b0, out_valid}, 8'd0);
    chk("fl_ready", {7'b0, in_ready}, 8'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_gone", {7'b0, out_valid}, 8'd0);

    // flush with one entry held while an accept would otherwise happen
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000); step();
    drive(7'b1101111, 3'b000, 7'b0000000); flush = 1'b1; step();
    chk("fl2_valid", {7'b0, out_valid}, 8'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl2_gone", {7'b0, out_valid}, 8'd0);

    // reset with skid full
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0100000); step();
    drive(7'b0110011, 3'b100, 7'b0000000); step();
    chk("rs_full", {7'b0, in_ready}, 8'd0);
    drive(7'b1101111, 3'b000, 7'b0000000); reset = 1'b1; step();
    chk("rs_valid", {7'b0, out_valid}, 8'd0);
    chk("rs_ready", {7'b0, in_ready}, 8'd1);
    chk("rs_op", {4'b0, Operation}, 8'd0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("rs_gone", {7'b0, out_valid}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
